// File: rtl/pixel_stream_sink_pkg.sv
// Shared definitions for the pixel stream sink and its raster position counter.
// Holds the receive FSM state type, the err_flags bit positions and the
// frame-geometry helper functions used to size counters and limits.
package pixel_stream_sink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_NOSOP = 2;

    // Number of pixels in one frame.
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    // Bits needed to hold a coordinate in 0..n-1 (at least one bit).
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_sink_if.sv
// Avalon-ST pixel stream bundle (valid/ready, ready latency 0).
// Ports:
//   sink_data           pixel value
//   sink_startofpacket  first pixel of a frame
//   sink_endofpacket    last pixel of a frame
//   sink_valid          beat valid
//   sink_ready          consumer can accept this cycle
// Modports: master (stream source), slave (stream consumer).
interface pixel_stream_sink_if #(
    parameter int DATA_W = 8
);
    import pixel_stream_sink_pkg::*;

    logic [DATA_W-1:0] sink_data;
    logic              sink_startofpacket;
    logic              sink_endofpacket;
    logic              sink_valid;
    logic              sink_ready;

    modport master (
        output sink_data, sink_startofpacket, sink_endofpacket, sink_valid,
        input  sink_ready
    );

    modport slave (
        input  sink_data, sink_startofpacket, sink_endofpacket, sink_valid,
        output sink_ready
    );

endinterface

// File: rtl/raster_pos_counter.sv
// Raster position counter: x, y and linear address of the current pixel.
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   i_clear       restart the position at (0,0) / address 0
//   i_advance     step one pixel (applied after i_clear when both are set)
//   o_x, o_y      current raster coordinates
//   o_addr        current linear address y*WIDTH+x, built incrementally
//   o_is_last     current position is the final pixel of the frame
module raster_pos_counter
    import pixel_stream_sink_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int X_W    = pos_width(WIDTH),
    parameter int Y_W    = pos_width(HEIGHT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [X_W-1:0]    o_x,
    output logic [Y_W-1:0]    o_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_is_last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    logic [X_W-1:0]    r_x, w_x_base, w_x_next;
    logic [Y_W-1:0]    r_y, w_y_base, w_y_next;
    logic [ADDR_W-1:0] r_addr, w_addr_base, w_addr_next;
    logic              w_base_last;

    // Clear selects the origin as the starting point, so clear+advance lands
    // on the pixel after the origin in a single cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_x_base    = i_clear ? '0 : r_x;
        w_y_base    = i_clear ? '0 : r_y;
        w_addr_base = i_clear ? '0 : r_addr;
        w_base_last = (w_x_base == X_LAST) && (w_y_base == Y_LAST);
        w_x_next    = w_x_base;
        w_y_next    = w_y_base;
        w_addr_next = w_addr_base;
        if (i_advance) begin
            if (w_base_last) begin
                w_x_next    = '0;
                w_y_next    = '0;
                w_addr_next = '0;
            end else if (w_x_base == X_LAST) begin
                w_x_next    = '0;
                w_y_next    = w_y_base + Y_W'(1);
                w_addr_next = w_addr_base + ADDR_W'(1);
            end else begin
                w_x_next    = w_x_base + X_W'(1);
                w_addr_next = w_addr_base + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_x    <= w_x_next;
            r_y    <= w_y_next;
            r_addr <= w_addr_next;
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_addr    = r_addr;
    assign o_is_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/pixel_stream_sink.sv
// Avalon-ST video packet receiver feeding a frame-buffer write port.
// Accepts framed pixels, writes each accepted pixel at its linear address and
// checks packet framing against the WIDTH x HEIGHT frame size.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   en             backpressure release; sink_ready follows it one cycle later
//   sink           pixel stream (slave side)
//   wr_en/addr/data  frame-buffer write port, one cycle after acceptance
//   frame_done     one-cycle pulse with the final write of a good frame
//   frame_count    number of good frames, wrapping
//   err_flags      sticky errors: [0] short, [1] long, [2] beat outside packet
//   err_clear      clears err_flags; a same-cycle new error keeps its bit
module pixel_stream_sink
    import pixel_stream_sink_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    pixel_stream_sink_if.slave  sink,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic [2:0]          err_flags,
    input  logic                err_clear
);

    localparam int FRAME_PIXELS = frame_pixels(WIDTH, HEIGHT);
    localparam int X_W          = pos_width(WIDTH);
    localparam int Y_W          = pos_width(HEIGHT);

    state_t              r_state, w_state_next;
    logic                r_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_done;
    logic [15:0]         r_count;
    logic [2:0]          r_err;

    logic                w_beat, w_sop, w_eop;
    logic                w_start, w_write, w_pos_clear, w_pos_adv, w_done;
    logic [2:0]          w_err_set;
    logic [X_W-1:0]      w_x;
    logic [Y_W-1:0]      w_y;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_is_last;

    assign w_beat = sink.sink_valid && r_ready;
    assign w_sop  = sink.sink_startofpacket;
    assign w_eop  = sink.sink_endofpacket;

    raster_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_pos_clear),
        .i_advance (w_pos_adv),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_addr    (w_addr),
        .o_is_last (w_is_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // w_start marks a beat that opens a new frame at address 0; it is shared
    // by IDLE, the mid-frame restart in ACTIVE and SOP-without-EOP in DRAIN.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_pos_clear  = 1'b0;
        w_pos_adv    = 1'b0;
        w_done       = 1'b0;
        w_err_set    = '0;
        if (w_beat) begin
            unique case (r_state)
                IDLE: begin
                    if (w_sop) w_start = 1'b1;
                    else       w_err_set[ERR_NOSOP] = 1'b1;
                end
                ACTIVE: begin
                    if (w_sop) begin
                        w_start              = 1'b1;
                        w_err_set[ERR_SHORT] = 1'b1;
                    end else begin
                        w_write = 1'b1;
                        if (w_is_last) begin
                            w_pos_clear = 1'b1;
                            if (w_eop) begin
                                w_done       = 1'b1;
                                w_state_next = IDLE;
                            end else begin
                                w_err_set[ERR_LONG] = 1'b1;
                                w_state_next        = DRAIN;
                            end
                        end else if (w_eop) begin
                            w_err_set[ERR_SHORT] = 1'b1;
                            w_pos_clear          = 1'b1;
                            w_state_next         = IDLE;
                        end else begin
                            w_pos_adv = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_eop)      w_state_next = IDLE;
                    else if (w_sop) w_start = 1'b1;
                end
                default: w_state_next = IDLE;
            endcase

            if (w_start) begin
                w_write     = 1'b1;
                w_pos_clear = 1'b1;
                if (w_eop) begin
                    w_state_next = IDLE;
                    if (FRAME_PIXELS == 1) w_done = 1'b1;
                    else                   w_err_set[ERR_SHORT] = 1'b1;
                end else begin
                    w_pos_adv    = 1'b1;
                    w_state_next = ACTIVE;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_err     <= '0;
        end else begin
            r_ready <= en;
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= w_start ? '0 : w_addr;
                r_wr_data <= sink.sink_data;
            end
            r_done <= w_done;
            if (w_done) r_count <= r_count + 16'd1;
            // Clear first, then OR in new errors so a same-cycle error survives.
            r_err <= (err_clear ? 3'b000 : r_err) | w_err_set;
        end
    end

    assign sink.sink_ready = r_ready;
    assign wr_en           = r_wr_en;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign frame_done      = r_done;
    assign frame_count     = r_count;
    assign err_flags       = r_err;

    // Cross-check the incrementally built address against the coordinates.
    a_addr_matches_xy: assert property (@(posedge clock) disable iff (reset)
        int'(w_addr) == int'(w_y) * WIDTH + int'(w_x));

endmodule
